// File: rtl/vec_sequencer.sv
// Vector-op sequencer: expands one decoded vector instruction into per-element
// micro-ops with rotated register indices and byte offsets, stalling fetch until done.
module vec_sequencer #(
  parameter int MAX_LEN = 8,
  parameter int LENW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              CondEx,
  input  logic [1:0]        VOp,
  input  logic [LENW-1:0]   VLen,
  input  logic [3:0]        Rd,
  input  logic [3:0]        Rn,
  input  logic [3:0]        Rm,
  input  logic              MemReady,
  output logic              Busy,
  output logic              StallF,
  output logic              ElemEn,
  output logic              ElemRegW,
  output logic              ElemMemW,
  output logic [3:0]        ElemRd,
  output logic [3:0]        ElemRn,
  output logic [3:0]        ElemRm,
  output logic [LENW-1:0]   ElemIdx,
  output logic [LENW+1:0]   AddrOff,
  output logic              Done,
  output logic              PCWriteErr
);

  // state | meaning
  // IDLE  | waiting for Start; datapath owned by the controller
  // ISSUE | element micro-op presented (ALU elements complete here)
  // WAIT  | load/store element waiting on MemReady
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]      OP_ALU   = 2'b00;
  localparam logic [1:0]      OP_LOAD  = 2'b01;
  localparam logic [1:0]      OP_STORE = 2'b10;
  localparam logic [1:0]      OP_RSVD  = 2'b11;
  localparam logic [LENW-1:0] MAX_LEN_W = LENW'(MAX_LEN);

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [3:0]        rd_q, rn_q, rm_q;
  logic [LENW-1:0]   len_q;
  logic [LENW-1:0]   idx_q;
  logic              err_q;

  logic [LENW-1:0]   len_clamped;
  logic              accept;
  logic              annul;
  logic              is_last;
  logic              idx_inc;
  logic              wr_req;
  logic              pc_hit;

  assign len_clamped = (VLen > MAX_LEN_W) ? MAX_LEN_W : VLen;
  assign accept      = (state_q == S_IDLE) && Start;
  assign annul       = !CondEx || (VOp == OP_RSVD) || (len_clamped == '0);
  assign is_last     = (idx_q == len_q - LENW'(1));

  assign ElemIdx = idx_q;
  assign AddrOff = {idx_q, 2'b00};
  assign ElemRd  = rd_q + 4'(idx_q);
  assign ElemRn  = rn_q + 4'(idx_q);
  assign ElemRm  = rm_q + 4'(idx_q);

  // A write aimed at R15 would clobber the PC: drop it and flag it instead.
  assign pc_hit     = wr_req && (ElemRd == 4'hf);
  assign ElemRegW   = wr_req && !pc_hit;
  assign PCWriteErr = err_q;

  assign Busy   = (state_q != S_IDLE);
  assign StallF = Busy || Start;

  always_comb begin
    state_d  = state_q;
    idx_inc  = 1'b0;
    wr_req   = 1'b0;
    ElemEn   = 1'b0;
    ElemMemW = 1'b0;
    Done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = annul ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        ElemEn = 1'b1;
        if (op_q == OP_ALU) begin
          wr_req = 1'b1;
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_inc = 1'b1;
          end
        end else begin
          ElemMemW = (op_q == OP_STORE);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MemReady) begin
          wr_req = (op_q == OP_LOAD);
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= VOp;
        rd_q  <= Rd;
        rn_q  <= Rn;
        rm_q  <= Rm;
        len_q <= len_clamped;
        idx_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (idx_inc) begin
          idx_q <= idx_q + LENW'(1);
        end
        if (pc_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_sequencer.sv
// Directed self-checking bench for vec_sequencer; cycle 0 is the cycle Start is driven.
module tb_vec_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start, CondEx, MemReady;
  logic [1:0] VOp;
  logic [3:0] VLen, Rd, Rn, Rm;
  logic       Busy, StallF, ElemEn, ElemRegW, ElemMemW, Done, PCWriteErr;
  logic [3:0] ElemRd, ElemRn, ElemRm, ElemIdx;
  logic [5:0] AddrOff;

  int n_checks = 0;
  int n_fail   = 0;

  // ctl = {Busy,StallF,ElemEn,ElemRegW,ElemMemW,Done,PCWriteErr}
  logic [6:0]  ctl, exp_ctl;
  logic [21:0] el, exp_el;
  assign ctl = {Busy, StallF, ElemEn, ElemRegW, ElemMemW, Done, PCWriteErr};
  assign el  = {ElemRd, ElemRn, ElemRm, ElemIdx, AddrOff};

  vec_sequencer #(.MAX_LEN(8), .LENW(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .CondEx(CondEx), .VOp(VOp), .VLen(VLen),
    .Rd(Rd), .Rn(Rn), .Rm(Rm), .MemReady(MemReady),
    .Busy(Busy), .StallF(StallF), .ElemEn(ElemEn), .ElemRegW(ElemRegW),
    .ElemMemW(ElemMemW), .ElemRd(ElemRd), .ElemRn(ElemRn), .ElemRm(ElemRm),
    .ElemIdx(ElemIdx), .AddrOff(AddrOff), .Done(Done), .PCWriteErr(PCWriteErr)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic cond, input logic [1:0] op, input logic [3:0] len,
                          input logic [3:0] d, input logic [3:0] n, input logic [3:0] m);
    Start = 1'b1; CondEx = cond; VOp = op; VLen = len; Rd = d; Rn = n; Rm = m;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    n_checks++;
    if (ctl !== 7'b0 || el !== 22'b0) begin
      n_fail++;
      $display("FAIL reset: ctl=%b el=%h, required ctl=0 el=0", ctl, el);
    end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_alu();
    start_op(1'b1, 2'b00, 4'd4, 4'd2, 4'd4, 4'd8);
    #1;
    n_checks++;
    if (ctl !== 7'b0100000) begin
      n_fail++; $display("FAIL alu_accept: ctl=%b required %b", ctl, 7'b0100000);
    end
    next_cycle();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_el = {4'(2 + i), 4'(4 + i), 4'(8 + i), 4'(i), 6'(4 * i)};
      n_checks++;
      if (ctl !== 7'b1111000 || el !== exp_el) begin
        n_fail++;
        $display("FAIL alu_elem%0d: ctl=%b el=%h required ctl=%b el=%h", i, ctl, el, 7'b1111000, exp_el);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin
      n_fail++; $display("FAIL alu_done: ctl=%b required %b", ctl, 7'b1100010);
    end
    next_cycle();
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_fail++; $display("FAIL alu_idle: ctl=%b required 0", ctl);
    end
    next_cycle();
  endtask

  task automatic test_load();
    logic       mr  [1:9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] ec  [1:9] = '{7'b1110000, 7'b1100000, 7'b1100000, 7'b1100000, 7'b1101000,
                              7'b1110000, 7'b1100000, 7'b1101000, 7'b1100010};
    int         eix [1:9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    start_op(1'b1, 2'b01, 4'd2, 4'd1, 4'd3, 4'd5);
    next_cycle();
    Start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      MemReady = mr[c];
      #1;
      exp_el = {4'(1 + eix[c]), 4'(3 + eix[c]), 4'(5 + eix[c]), 4'(eix[c]), 6'(4 * eix[c])};
      n_checks++;
      if (ctl !== ec[c] || el !== exp_el) begin
        n_fail++;
        $display("FAIL load_cyc%0d: ctl=%b el=%h required ctl=%b el=%h", c, ctl, el, ec[c], exp_el);
      end
      next_cycle();
    end
    MemReady = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_fail++; $display("FAIL load_idle: ctl=%b required 0", ctl);
    end
    next_cycle();
  endtask

  task automatic test_store();
    logic [6:0] ec [1:4] = '{7'b1110100, 7'b1100000, 7'b1100010, 7'b0000000};
    start_op(1'b1, 2'b10, 4'd1, 4'd15, 4'd2, 4'd3);
    next_cycle();
    Start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      MemReady = (c == 2);
      #1;
      n_checks++;
      if (ctl !== ec[c]) begin
        n_fail++; $display("FAIL store_cyc%0d: ctl=%b required %b", c, ctl, ec[c]);
      end
      next_cycle();
    end
    MemReady = 1'b0;
  endtask

  task automatic test_pcwrap();
    logic [6:0] ec [1:3] = '{7'b1111000, 7'b1110000, 7'b1111001};
    logic [3:0] erd [1:3] = '{4'd14, 4'd15, 4'd0};
    start_op(1'b1, 2'b00, 4'd3, 4'd14, 4'd0, 4'd0);
    next_cycle();
    Start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_checks++;
      if (ctl !== ec[c] || ElemRd !== erd[c]) begin
        n_fail++;
        $display("FAIL pcwrap_cyc%0d: ctl=%b rd=%0d required ctl=%b rd=%0d", c, ctl, ElemRd, ec[c], erd[c]);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (ctl !== 7'b1100011) begin
      n_fail++; $display("FAIL pcwrap_done: ctl=%b required %b", ctl, 7'b1100011);
    end
    next_cycle();
    #1;
    n_checks++;
    if (ctl !== 7'b0000001) begin
      n_fail++; $display("FAIL pcwrap_sticky: ctl=%b required %b", ctl, 7'b0000001);
    end
    start_op(1'b0, 2'b00, 4'd2, 4'd0, 4'd0, 4'd0);
    #1;
    n_checks++;
    if (ctl !== 7'b0100001) begin
      n_fail++; $display("FAIL pcwrap_hold_at_start: ctl=%b required %b", ctl, 7'b0100001);
    end
    next_cycle();
    Start = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin
      n_fail++; $display("FAIL pcwrap_cleared: ctl=%b required %b", ctl, 7'b1100010);
    end
    next_cycle();
  endtask

  task automatic test_annul();
    logic       cnd [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] op  [3] = '{2'b00, 2'b00, 2'b11};
    logic [3:0] ln  [3] = '{4'd4, 4'd0, 4'd4};
    for (int k = 0; k < 3; k++) begin
      start_op(cnd[k], op[k], ln[k], 4'd1, 4'd1, 4'd1);
      next_cycle();
      Start = 1'b0;
      #1;
      n_checks++;
      if (ctl !== 7'b1100010) begin
        n_fail++; $display("FAIL annul%0d_done: ctl=%b required %b", k, ctl, 7'b1100010);
      end
      next_cycle();
      #1;
      n_checks++;
      if (ctl !== 7'b0000000) begin
        n_fail++; $display("FAIL annul%0d_idle: ctl=%b required 0", k, ctl);
      end
      next_cycle();
    end
  endtask

  task automatic test_clamp();
    start_op(1'b1, 2'b00, 4'd12, 4'd3, 4'd6, 4'd9);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 7) begin
        start_op(1'b1, 2'b01, 4'd1, 4'd9, 4'd9, 4'd9);
      end else begin
        Start = 1'b0;
      end
      #1;
      exp_el = {4'(3 + i), 4'(6 + i), 4'(9 + i), 4'(i), 6'(4 * i)};
      n_checks++;
      if (ctl !== 7'b1111000 || el !== exp_el) begin
        n_fail++;
        $display("FAIL clamp_elem%0d: ctl=%b el=%h required ctl=%b el=%h", i, ctl, el, 7'b1111000, exp_el);
      end
      next_cycle();
    end
    start_op(1'b1, 2'b00, 4'd2, 4'd0, 4'd0, 4'd0);
    #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin
      n_fail++; $display("FAIL clamp_done: ctl=%b required %b", ctl, 7'b1100010);
    end
    next_cycle();
    Start = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_fail++; $display("FAIL clamp_start_in_done: ctl=%b required 0", ctl);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    start_op(1'b1, 2'b01, 4'd2, 4'd5, 4'd6, 4'd7);
    next_cycle();
    Start = 1'b0;
    MemReady = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 7'b0 || el !== 22'b0) begin
      n_fail++; $display("FAIL rst_mid: ctl=%b el=%h required ctl=0 el=0", ctl, el);
    end
    next_cycle();
    #1;
    n_checks++;
    if (ctl !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid_no_done: ctl=%b required 0", ctl);
    end
    start_op(1'b1, 2'b00, 4'd1, 4'd7, 4'd1, 4'd2);
    next_cycle();
    Start = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 7'b1111000 || ElemRd !== 4'd7) begin
      n_fail++; $display("FAIL rst_mid_restart: ctl=%b rd=%0d required ctl=%b rd=7", ctl, ElemRd, 7'b1111000);
    end
    next_cycle();
    #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin
      n_fail++; $display("FAIL rst_mid_restart_done: ctl=%b required %b", ctl, 7'b1100010);
    end
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; CondEx = 1'b0; MemReady = 1'b0;
    VOp = 2'b00; VLen = 4'd0; Rd = 4'd0; Rn = 4'd0; Rm = 4'd0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_pcwrap();
    test_annul();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
